// File: rtl/div_pkg.sv
// div_pkg: quotient-digit encodings and converter state encoding shared by the SRT divider
package div_pkg;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_ILL  = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} otf_state_t;
endpackage

// File: rtl/otf_step.sv
// otf_step: one on-the-fly conversion step; illegal digits behave as zero
module otf_step
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]     i_digit,
  input  logic [WIDTH:0] i_q,
  input  logic [WIDTH:0] i_qm,
  output logic [WIDTH:0] o_q,
  output logic [WIDTH:0] o_qm
);
  always_comb begin
    o_q  = i_digit == DIG_POS ? {i_q[WIDTH-1:0], 1'b1} :
           i_digit == DIG_NEG ? {i_qm[WIDTH-1:0], 1'b1} : {i_q[WIDTH-1:0], 1'b0};
    o_qm = i_digit == DIG_POS ? {i_q[WIDTH-1:0], 1'b0} :
           i_digit == DIG_NEG ? {i_qm[WIDTH-1:0], 1'b0} : {i_qm[WIDTH-1:0], 1'b1};
  end
endmodule

// File: rtl/otf_quotient_converter.sv
// otf_quotient_converter: signed-digit quotient stream to two's-complement with remainder-sign fix.
// Define DIGIT_CHECK_EN to enable the sticky illegal-digit flag.
module otf_quotient_converter
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           digit_valid,
  input  logic [1:0]     digit,
  output logic           digit_ready,
  input  logic           fix_valid,
  input  logic           rem_neg,
  output logic           busy,
  output logic           done,
  output logic [WIDTH:0] quotient,
  output logic           digit_err
);
  localparam int CW = $clog2(WIDTH + 1);
  otf_state_t r_state, w_next;
  logic [WIDTH:0] r_q, r_qm, r_quot, w_q_next, w_qm_next;
  logic [CW-1:0]  r_count;
  logic           r_done, w_acc, w_start, w_fix;
  otf_step #(.WIDTH(WIDTH)) u_step (
    .i_digit(digit),
    .i_q    (r_q),
    .i_qm   (r_qm),
    .o_q    (w_q_next),
    .o_qm   (w_qm_next)
  );
  assign w_start     = r_state == IDLE && start;
  assign w_acc       = r_state == RUN && digit_valid;
  assign w_fix       = r_state == FIX && fix_valid;
  assign digit_ready = r_state == RUN;
  assign busy        = r_state == RUN || r_state == FIX;
  assign done        = r_done;
  assign quotient    = r_quot;
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_acc && r_count == CW'(WIDTH - 1) ? FIX : RUN) :
             r_state == FIX  ? (fix_valid ? IDLE : FIX) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_qm    <= '1;
      r_count <= '0;
      r_quot  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_start) begin
        r_q     <= '0;
        r_qm    <= '1;
        r_count <= '0;
      end else if (w_acc) begin
        r_q     <= w_q_next;
        r_qm    <= w_qm_next;
        r_count <= r_count + 1'b1;
      end
      if (w_fix) r_quot <= rem_neg ? r_qm : r_q;
    end
  end
`ifdef DIGIT_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (w_start) r_err <= 1'b0;
    else if (w_acc && digit == DIG_ILL) r_err <= 1'b1;
  end
  assign digit_err = r_err;
`else
  assign digit_err = 1'b0;
`endif
endmodule

// File: tb/tb_otf_quotient_converter.sv
// tb_otf_quotient_converter: directed and random conversions checked against an arithmetic model
module tb_otf_quotient_converter;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         digit_valid = 1'b0;
  logic [1:0]   digit = 2'b00;
  logic         digit_ready;
  logic         fix_valid = 1'b0;
  logic         rem_neg = 1'b0;
  logic         busy;
  logic         done;
  logic [W:0]   quotient;
  logic         digit_err;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W:0]   prev_q = '0;
  otf_quotient_converter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .digit_valid(digit_valid),
    .digit      (digit),
    .digit_ready(digit_ready),
    .fix_valid  (fix_valid),
    .rem_neg    (rem_neg),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .digit_err  (digit_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Digit value: +1, -1, or 0 (zero and illegal code)
  function automatic int dval(input logic [1:0] d);
    return d == 2'b10 ? 1 : d == 2'b01 ? -1 : 0;
  endfunction
  task automatic run(input string tag, input logic [7:0] ds, input logic rn, input int stall);
    int v;
    logic ill;
    logic [1:0] d;
    logic [W:0] exp_q;
    v = 0;
    ill = 1'b0;
    chk({tag, "_held"}, 32'(quotient), 32'(prev_q));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    chk({tag, "_err_clr"}, 32'(digit_err), 32'd0);
    for (int i = 0; i < W; i++) begin
      d = ds[7-2*i -: 2];
      repeat (stall) begin
        digit_valid = 1'b0;
        start = 1'b1;
        fix_valid = 1'b1;
        rem_neg = ~rn;
        tick();
      end
      start = 1'b0;
      fix_valid = 1'b0;
      chk({tag, "_ready"}, 32'(digit_ready), 32'd1);
      digit_valid = 1'b1;
      digit = d;
      tick();
      digit_valid = 1'b0;
      v = 2 * v + dval(d);
      ill = ill | (d == 2'b11);
    end
    chk({tag, "_fix_busy"}, 32'(busy), 32'd1);
    chk({tag, "_fix_ready"}, 32'(digit_ready), 32'd0);
    repeat (stall) tick();
    chk({tag, "_no_done"}, 32'(done), 32'd0);
    chk({tag, "_q_before"}, 32'(quotient), 32'(prev_q));
    fix_valid = 1'b1;
    rem_neg = rn;
    tick();
    fix_valid = 1'b0;
    exp_q = (W + 1)'(v - int'(rn));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_quot"}, 32'(quotient), 32'(exp_q));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef DIGIT_CHECK_EN
    chk({tag, "_err"}, 32'(digit_err), 32'(ill));
`else
    chk({tag, "_err"}, 32'(digit_err), 32'd0);
`endif
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_quot_hold"}, 32'(quotient), 32'(exp_q));
    prev_q = exp_q;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(digit_ready), 32'd0);
    chk("rst_err", 32'(digit_err), 32'd0);
    rst = 1'b0;
    tick();
    digit_valid = 1'b1;
    fix_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    fix_valid = 1'b0;
    chk("idle_ignore_busy", 32'(busy), 32'd0);
    chk("idle_ignore_done", 32'(done), 32'd0);
    run("s1", 8'b10_00_01_10, 1'b0, 0);
    run("s2", 8'b10_00_01_10, 1'b1, 0);
    run("s3a", 8'b01_01_01_01, 1'b0, 0);
    run("s3b", 8'b00_00_00_00, 1'b1, 0);
    run("s4", 8'b10_00_01_10, 1'b0, 3);
    run("s6", 8'b10_11_00_00, 1'b0, 0);
    run("s6_clr", 8'b10_00_00_00, 1'b0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      digit_valid = 1'b1;
      digit = 2'b10;
      tick();
    end
    digit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("s5_quot", 32'(quotient), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    chk("s5_ready", 32'(digit_ready), 32'd0);
    chk("s5_err", 32'(digit_err), 32'd0);
    tick();
    rst = 1'b0;
    prev_q = '0;
    run("s5_after", 8'b10_00_01_10, 1'b0, 0);
    for (int k = 0; k < 24; k++)
      run("rnd", 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/otf_quotient_converter.md
Name: otf_quotient_converter

Overview:
On-the-fly converter for the radix-2 SRT divider datapath. It consumes the signed-digit quotient stream produced by the quotient-digit selection stage, one digit per accepted cycle, MSB first. It keeps the Q and QM (Q − 1 ulp) registers and applies the final remainder-sign correction. Its output is a conventional two's-complement quotient, so the divider needs no carry-propagate adder at the end.

Parameters:
WIDTH, 16, number of quotient digits per division; result registers are WIDTH+1 bits, two's complement.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a new conversion; honoured only in IDLE
digit_valid  input  1  digit carries a new quotient digit
digit  input  2  signed digit: 2'b10 = +1, 2'b01 = −1, 2'b00 = 0, 2'b11 illegal
digit_ready  output  1  high only in RUN; digit accepted when digit_valid && digit_ready
fix_valid  input  1  final remainder sign presented
rem_neg  input  1  final partial remainder negative; qualified by fix_valid
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse when quotient is updated
quotient  output  WIDTH+1  corrected two's-complement quotient; held until next start
digit_err  output  1  sticky illegal-digit flag (see Optional Feature)

Behaviour:
- Reset (async, any state): state = IDLE; Q = 0; QM = all ones; count = 0; quotient = 0; done = 0; busy = 0; digit_err = 0.
- States:
  - IDLE
    - start: Q ← 0, QM ← all ones, count ← 0, digit_err ← 0; go to RUN next cycle.
    - digit_valid and fix_valid are ignored.
  - RUN: on each accepted digit, update Q/QM as below and increment count. The accept with count == WIDTH−1 moves to FIX.
    - +1: Q ← {Q[WIDTH−1:0], 1}; QM ← {Q[WIDTH−1:0], 0}
    - 0: Q ← {Q[WIDTH−1:0], 0}; QM ← {QM[WIDTH−1:0], 1}
    - −1: Q ← {QM[WIDTH−1:0], 1}; QM ← {QM[WIDTH−1:0], 0}
    - Invariant after every step: QM = Q − 1 (mod 2^(WIDTH+1)).
  - FIX
    - Waits indefinitely for fix_valid.
    - On fix_valid: quotient ← rem_neg ? QM : Q; done = 1 for exactly that one cycle; go to IDLE.
- Latency: quotient and done appear the cycle after fix_valid is sampled in FIX. Minimum start-to-done is WIDTH+2 cycles.
- start outside IDLE is ignored; there is no abort, only rst.
- A digit stall (digit_valid low) holds all state; count does not advance.
- Illegal digit 2'b11 is processed as 0 and increments count.
- Q/QM shifts discard the MSB. The (WIDTH+1)-bit width is sufficient because |Σ q_i·2^(WIDTH−i)| < 2^WIDTH.
- quotient changes only in the FIX→IDLE transition and on rst.
- busy = (state == RUN || state == FIX); digit_ready = (state == RUN). Both are registered-state decodes with no combinational path from inputs.

Optional Feature:
Macro DIGIT_CHECK_EN.
- Defined: an accepted digit == 2'b11 sets digit_err. digit_err stays set until the next accepted start or rst. The digit is still processed as 0.
- Undefined: digit_err is tied to 0 and no check logic is present; 2'b11 is still processed as 0.

Decomposition:
- Package div_pkg holds:
  - localparams DIG_POS = 2'b10, DIG_NEG = 2'b01, DIG_ZERO = 2'b00, DIG_ILL = 2'b11, shared with the quotient-digit selection stage;
  - the state encoding for IDLE, RUN, FIX.
- One combinational sub-module, otf_step: inputs digit, Q, QM; outputs next Q and next QM. The top level holds the FSM, counter, handshake and registers.

Test Plan (WIDTH = 4 unless noted):
1. start; digits +1, 0, −1, +1; fix_valid with rem_neg = 0 → quotient = 5'b00111 (7), done pulses once, busy falls the same cycle.
2. Same digits, rem_neg = 1 → quotient = 5'b00110 (6).
3. Digits −1, −1, −1, −1, rem_neg = 0 → quotient = 5'b10001 (−15). Digits 0, 0, 0, 0 with rem_neg = 1 → 5'b11111 (−1).
4. Scenario 1 with digit_valid low for 3 cycles between digits, plus start and fix_valid pulses in RUN → same result. Early fix_valid and mid-run start have no effect.
5. Assert rst after 2 digits → all outputs return to reset values immediately; a subsequent full run gives the correct result.
6. With DIGIT_CHECK_EN: digits +1, 2'b11, 0, 0, rem_neg = 0 → digit_err = 1, quotient = 5'b01000 (8). digit_err clears on the next start. Without the macro, digit_err stays 0 and quotient is the same.
